// File: rtl/led_frame_buffer.sv
// led_frame_buffer
//   Double-buffered per-LED colour store for the WS281x strand driver.
//   Pattern/host logic writes the back bank while the driver reads GRB
//   triples from the front bank. The banks swap only when the driver reads
//   the last LED, so a strand never shows a half-updated frame.
//
//   Optional feature macro: BRIGHTNESS_SCALE_EN
//     defined   -> brightness port present, each channel is scaled by
//                  (brightness+1)/256, read latency 2
//     undefined -> no brightness port, read latency 1
//
// Ports
//   clk_in                    system clock
//   rst_in                    synchronous reset, active-high
//   req_idx / req_valid       driver read request
//   green_out/red_out/blue_out front-bank colour of the served request
//   color_valid               one-cycle pulse, colour outputs valid
//   wr_en / wr_idx / wr_*     back-bank write, accepted when wr_en & wr_ready
//   wr_ready                  high only in RUN
//   swap_req                  pulse, request a bank swap at next frame end
//   swap_done                 one-cycle pulse when the swap takes effect
//   brightness                global scale (BRIGHTNESS_SCALE_EN only)
//
// state   | meaning
// --------+----------------------------------------------------------
// S_CLEAR | zeroing both banks, one index per cycle; writes refused
// S_RUN   | writes go to back bank; swap_req arms a swap
// S_PEND  | swap armed, waiting for last-index request; writes refused

module led_frame_buffer #(
  parameter int NUM_LEDS = 2,
  parameter int COLOR_W  = 8,
  localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [IDX_W-1:0]   req_idx,
  input  logic               req_valid,
  output logic [COLOR_W-1:0] green_out,
  output logic [COLOR_W-1:0] red_out,
  output logic [COLOR_W-1:0] blue_out,
  output logic               color_valid,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [COLOR_W-1:0] wr_green,
  input  logic [COLOR_W-1:0] wr_red,
  input  logic [COLOR_W-1:0] wr_blue,
  output logic               wr_ready,
  input  logic               swap_req,
`ifdef BRIGHTNESS_SCALE_EN
  input  logic [7:0]         brightness,
`endif
  output logic               swap_done
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;

  localparam int PIX_W = 3 * COLOR_W;
  localparam logic [IDX_W:0]   NUM_X    = (IDX_W+1)'(NUM_LEDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] clr_cnt;
  logic             front_sel;

  // Pixels packed as {green, red, blue}.
  logic [PIX_W-1:0] bank0 [NUM_LEDS];
  logic [PIX_W-1:0] bank1 [NUM_LEDS];

  logic             req_in_range;
  logic             wr_in_range;
  logic             boundary;
  logic             wr_accept;
  logic [PIX_W-1:0] rd_pix;

  always_comb begin
    req_in_range = ({1'b0, req_idx} < NUM_X);
    wr_in_range  = ({1'b0, wr_idx} < NUM_X);
    // Out-of-range indices never mark the end of a frame.
    boundary     = req_valid && req_in_range && (req_idx == LAST_IDX);
    wr_accept    = (state == S_RUN) && wr_en && wr_in_range;
    // Banks are only partly zeroed during CLEAR, so serve black explicitly.
    rd_pix = '0;
    if (req_in_range && (state != S_CLEAR))
      rd_pix = front_sel ? bank1[req_idx] : bank0[req_idx];
  end

  assign wr_ready = (state == S_RUN);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_CLEAR;
      clr_cnt   <= '0;
      front_sel <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == LAST_IDX) begin
            clr_cnt <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (swap_req) begin
            // Swap request coinciding with the last-index read takes effect
            // at this very boundary; the read itself still sees the old bank.
            if (boundary) begin
              front_sel <= ~front_sel;
              swap_done <= 1'b1;
            end else begin
              state <= S_PEND;
            end
          end
        end
        S_PEND: begin
          if (boundary) begin
            front_sel <= ~front_sel;
            swap_done <= 1'b1;
            state     <= S_RUN;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  // Bank storage carries no reset so it can map onto RAM; CLEAR zeroes it.
  always_ff @(posedge clk_in) begin
    if (!rst_in && (state == S_CLEAR)) begin
      bank0[clr_cnt] <= '0;
      bank1[clr_cnt] <= '0;
    end else if (!rst_in && wr_accept) begin
      if (front_sel)
        bank0[wr_idx] <= {wr_green, wr_red, wr_blue};
      else
        bank1[wr_idx] <= {wr_green, wr_red, wr_blue};
    end
  end

`ifdef BRIGHTNESS_SCALE_EN
  logic             s1_valid;
  logic [PIX_W-1:0] s1_pix;
  logic [7:0]       s1_bri;

  // (c * (b+1)) >> 8 : b=255 leaves c unchanged, b=0 gives black.
  function automatic logic [COLOR_W-1:0] scale(input logic [COLOR_W-1:0] c,
                                               input logic [7:0]         b);
    logic [8:0]         b_plus;
    logic [COLOR_W+8:0] prod;
    b_plus = {1'b0, b} + 9'd1;
    prod   = {{9{1'b0}}, c} * {{COLOR_W{1'b0}}, b_plus};
    return prod[COLOR_W+7:8];
  endfunction

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid    <= 1'b0;
      s1_pix      <= '0;
      s1_bri      <= '0;
      color_valid <= 1'b0;
      green_out   <= '0;
      red_out     <= '0;
      blue_out    <= '0;
    end else begin
      s1_valid    <= req_valid;
      s1_pix      <= rd_pix;
      s1_bri      <= brightness;
      color_valid <= s1_valid;
      green_out   <= scale(s1_pix[PIX_W-1 -: COLOR_W], s1_bri);
      red_out     <= scale(s1_pix[2*COLOR_W-1 -: COLOR_W], s1_bri);
      blue_out    <= scale(s1_pix[COLOR_W-1:0], s1_bri);
    end
  end
`else
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      color_valid <= 1'b0;
      green_out   <= '0;
      red_out     <= '0;
      blue_out    <= '0;
    end else begin
      color_valid <= req_valid;
      green_out   <= rd_pix[PIX_W-1 -: COLOR_W];
      red_out     <= rd_pix[2*COLOR_W-1 -: COLOR_W];
      blue_out    <= rd_pix[COLOR_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer
//   Directed bench for led_frame_buffer. Main instance uses NUM_LEDS=4;
//   a second instance with NUM_LEDS=5 (3-bit index) exercises out-of-range
//   request and write indices.

module tb_led_frame_buffer;

`ifdef BRIGHTNESS_SCALE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0] req_idx = '0;
  logic       req_valid = 1'b0;
  logic [7:0] green_out, red_out, blue_out;
  logic       color_valid;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [7:0] wr_green = '0, wr_red = '0, wr_blue = '0;
  logic       wr_ready;
  logic       swap_req = 1'b0;
  logic       swap_done;

  logic [2:0] req_idx5 = '0;
  logic       req_valid5 = 1'b0;
  logic [7:0] green5, red5, blue5;
  logic       color_valid5;
  logic       wr_en5 = 1'b0;
  logic [2:0] wr_idx5 = '0;
  logic [7:0] wr_green5 = '0, wr_red5 = '0, wr_blue5 = '0;
  logic       wr_ready5;
  logic       swap_req5 = 1'b0;
  logic       swap_done5;

`ifdef BRIGHTNESS_SCALE_EN
  logic [7:0] brightness = 8'd255;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_frame_buffer #(.NUM_LEDS(4), .COLOR_W(8)) u_dut (
    .clk_in(clk), .rst_in(rst),
    .req_idx(req_idx), .req_valid(req_valid),
    .green_out(green_out), .red_out(red_out), .blue_out(blue_out),
    .color_valid(color_valid),
    .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_green(wr_green), .wr_red(wr_red), .wr_blue(wr_blue),
    .wr_ready(wr_ready), .swap_req(swap_req),
`ifdef BRIGHTNESS_SCALE_EN
    .brightness(brightness),
`endif
    .swap_done(swap_done)
  );

  led_frame_buffer #(.NUM_LEDS(5), .COLOR_W(8)) u_dut5 (
    .clk_in(clk), .rst_in(rst),
    .req_idx(req_idx5), .req_valid(req_valid5),
    .green_out(green5), .red_out(red5), .blue_out(blue5),
    .color_valid(color_valid5),
    .wr_en(wr_en5), .wr_idx(wr_idx5),
    .wr_green(wr_green5), .wr_red(wr_red5), .wr_blue(wr_blue5),
    .wr_ready(wr_ready5), .swap_req(swap_req5),
`ifdef BRIGHTNESS_SCALE_EN
    .brightness(brightness),
`endif
    .swap_done(swap_done5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request; swap_done is checked one cycle after the request,
  // colour outputs after the read latency. Single-cycle strobes drop here.
  task automatic do_read(input string tag, input logic [1:0] idx,
                         input logic [7:0] eg, input logic [7:0] er,
                         input logic [7:0] eb, input logic es);
    req_valid = 1'b1;
    req_idx   = idx;
    tick();
    req_valid = 1'b0;
    swap_req  = 1'b0;
    wr_en     = 1'b0;
    chk({tag, "/swap"}, {31'd0, swap_done}, {31'd0, es});
    for (int k = 1; k < LAT; k++) tick();
    chk({tag, "/vld"}, {31'd0, color_valid}, 32'd1);
    chk({tag, "/pix"}, {8'd0, green_out, red_out, blue_out}, {8'd0, eg, er, eb});
  endtask

  task automatic do_read5(input string tag, input logic [2:0] idx,
                          input logic [7:0] eg, input logic [7:0] er,
                          input logic [7:0] eb, input logic es);
    req_valid5 = 1'b1;
    req_idx5   = idx;
    tick();
    req_valid5 = 1'b0;
    swap_req5  = 1'b0;
    wr_en5     = 1'b0;
    chk({tag, "/swap"}, {31'd0, swap_done5}, {31'd0, es});
    for (int k = 1; k < LAT; k++) tick();
    chk({tag, "/vld"}, {31'd0, color_valid5}, 32'd1);
    chk({tag, "/pix"}, {8'd0, green5, red5, blue5}, {8'd0, eg, er, eb});
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst/vld", {31'd0, color_valid}, 32'd0);
    chk("rst/swap", {31'd0, swap_done}, 32'd0);
    chk("rst/wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst/green", {24'd0, green_out}, 32'd0);

    // CLEAR lasts NUM_LEDS cycles; back-to-back requests served as black
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("clr/wr_ready", {31'd0, wr_ready}, 32'd0);
      req_valid = 1'b1;
      req_idx   = 2'(3 - i);
      tick();
      if (i >= LAT - 1) begin
        chk("clr/vld", {31'd0, color_valid}, 32'd1);
        chk("clr/pix", {8'd0, green_out, red_out, blue_out}, 32'd0);
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < LAT; k++) tick();
    chk("run/wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("idle/vld", {31'd0, color_valid}, 32'd0);
    do_read("t1/r0", 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t1/r1", 2'd1, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t1/r2", 2'd2, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t1/r3", 2'd3, 8'd0, 8'd0, 8'd0, 1'b0);

    // Write idx1, arm swap, frame boundary at idx3
    wr_en = 1'b1; wr_idx = 2'd1; wr_green = 8'd10; wr_red = 8'd20; wr_blue = 8'd30;
    tick();
    wr_en = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("t2/pend_wr_ready", {31'd0, wr_ready}, 32'd0);
    do_read("t2/r0", 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t2/r1_old", 2'd1, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t2/r2", 2'd2, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t2/r3_swap", 2'd3, 8'd0, 8'd0, 8'd0, 1'b1);
    do_read("t2/r1_new", 2'd1, 8'd10, 8'd20, 8'd30, 1'b0);

    // swap_req together with last-index request in RUN
    wr_en = 1'b1; wr_idx = 2'd2; wr_green = 8'd1; wr_red = 8'd2; wr_blue = 8'd3;
    tick();
    wr_en = 1'b0;
    swap_req = 1'b1;
    do_read("t3/r3_same", 2'd3, 8'd0, 8'd0, 8'd0, 1'b1);
    chk("t3/wr_ready", {31'd0, wr_ready}, 32'd1);
    do_read("t3/r2_new", 2'd2, 8'd1, 8'd2, 8'd3, 1'b0);
    do_read("t3/r1_new", 2'd1, 8'd0, 8'd0, 8'd0, 1'b0);

    // Write with swap_req accepted; write during PENDING dropped
    wr_en = 1'b1; wr_idx = 2'd0; wr_green = 8'd40; wr_red = 8'd50; wr_blue = 8'd60;
    swap_req = 1'b1;
    tick();
    wr_en = 1'b0;
    swap_req = 1'b0;
    chk("t4/pend_wr_ready", {31'd0, wr_ready}, 32'd0);
    wr_en = 1'b1; wr_idx = 2'd1; wr_green = 8'd70; wr_red = 8'd80; wr_blue = 8'd90;
    tick();
    wr_en = 1'b0;
    do_read("t4/r0", 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t4/r2", 2'd2, 8'd1, 8'd2, 8'd3, 1'b0);
    do_read("t4/r3_swap", 2'd3, 8'd0, 8'd0, 8'd0, 1'b1);
    do_read("t4/r0_new", 2'd0, 8'd40, 8'd50, 8'd60, 1'b0);
    do_read("t4/r1_kept", 2'd1, 8'd10, 8'd20, 8'd30, 1'b0);

    // Out-of-range indices on the 5-LED instance
    wr_en5 = 1'b1; wr_idx5 = 3'd4; wr_green5 = 8'd5; wr_red5 = 8'd6; wr_blue5 = 8'd7;
    tick();
    wr_idx5 = 3'd6; wr_green5 = 8'd9; wr_red5 = 8'd9; wr_blue5 = 8'd9;
    tick();
    wr_en5 = 1'b0;
    swap_req5 = 1'b1;
    tick();
    swap_req5 = 1'b0;
    do_read5("t4b/r7", 3'd7, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read5("t4b/r4_swap", 3'd4, 8'd0, 8'd0, 8'd0, 1'b1);
    do_read5("t4b/r4_new", 3'd4, 8'd5, 8'd6, 8'd7, 1'b0);

    // Reset during PENDING discards the swap and clears both banks
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("t5/pend", {31'd0, wr_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      swap_req  = 1'b1;
      req_valid = 1'b1;
      req_idx   = 2'd3;
      tick();
      chk("t5/clr_swap", {31'd0, swap_done}, 32'd0);
    end
    swap_req  = 1'b0;
    req_valid = 1'b0;
    for (int k = 0; k < LAT; k++) tick();
    chk("t5/run_not_pend", {31'd0, wr_ready}, 32'd1);
    do_read("t5/r0", 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t5/r1", 2'd1, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t5/r3_noswap", 2'd3, 8'd0, 8'd0, 8'd0, 1'b0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    do_read("t5/r3_swap", 2'd3, 8'd0, 8'd0, 8'd0, 1'b1);
    do_read("t5/r0_other", 2'd0, 8'd0, 8'd0, 8'd0, 1'b0);
    do_read("t5/r1_other", 2'd1, 8'd0, 8'd0, 8'd0, 1'b0);

`ifdef BRIGHTNESS_SCALE_EN
    wr_en = 1'b1; wr_idx = 2'd2; wr_green = 8'd200; wr_red = 8'd255; wr_blue = 8'd0;
    tick();
    wr_en = 1'b0;
    swap_req = 1'b1;
    do_read("t6/r3_swap", 2'd3, 8'd0, 8'd0, 8'd0, 1'b1);
    brightness = 8'd127;
    do_read("t6/half", 2'd2, 8'd100, 8'd127, 8'd0, 1'b0);
    brightness = 8'd255;
    do_read("t6/full", 2'd2, 8'd200, 8'd255, 8'd0, 1'b0);
    brightness = 8'd0;
    do_read("t6/black", 2'd2, 8'd0, 8'd0, 8'd0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
